// File: rtl/key_event_pkg.sv
// key_event_pkg
// Shared types and constants for the key event block and its neighbours.
//   state_t           : FSM state encoding (3 bits)
//   *_12M constants   : default timing at the 12 MHz sys_clk, also used by
//                       the key debounce stage so both agree on the clock
package key_event_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      WAIT2  = 3'd2,
      PRESS2 = 3'd3,
      LONG   = 3'd4
   } state_t;

   localparam int SYS_CLK_HZ         = 12_000_000;
   localparam int DEBOUNCE_TIME_12M  = 120_000;     // 10 ms
   localparam int LONG_TIME_12M      = 12_000_000;  // 1 s
   localparam int DCLICK_TIME_12M    = 3_600_000;   // 300 ms
   localparam int REPEAT_TIME_12M    = 2_400_000;   // 200 ms
   localparam int CNT_BITS_12M       = 24;

endpackage

// File: rtl/key_event_if.sv
// key_event_if
// Bundles the debounced key level and the event outputs of one button.
//   key_i     : debounced key level (driven by the debounce stage)
//   held_o    : registered "key pressed" level
//   press_o / release_o / click_o / dclick_o / long_o / repeat_o :
//               single-cycle event pulses
// The slave modport is the key_event block; the master modport is the
// consumer side that supplies key_i and reads the events.
// There is no handshake: key_i is a plain level and each event is a
// one-cycle pulse that the consumer must sample on the cycle it is high.
interface key_event_if;
   logic key_i;
   logic held_o;
   logic press_o;
   logic release_o;
   logic click_o;
   logic dclick_o;
   logic long_o;
   logic repeat_o;

   modport slave (
      input  key_i,
      output held_o, press_o, release_o, click_o, dclick_o, long_o, repeat_o
   );

   modport master (
      output key_i,
      input  held_o, press_o, release_o, click_o, dclick_o, long_o, repeat_o
   );
endinterface

// File: rtl/key_edge.sv
// key_edge
// Normalises the key polarity and finds press/release edges.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   key_i            : debounced key level
//   key_d            : pressed state from the previous cycle (registered)
//   rise             : key pressed this cycle, released last cycle
//   fall             : key released this cycle, pressed last cycle
module key_edge #(
   parameter logic ACTIVE_LEVEL = 1'b1
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_i,
   output logic key_d,
   output logic rise,
   output logic fall
);

   logic pressed;

   assign pressed = (key_i == ACTIVE_LEVEL);

   // Reset to "released" so a key held through reset yields a rise
   // on the first cycle out of reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) key_d <= 1'b0;
      else         key_d <= pressed;
   end

   assign rise = pressed & ~key_d;
   assign fall = ~pressed & key_d;

endmodule

// File: rtl/key_event.sv
// key_event
// Turns a debounced key level into single-cycle UI events: press, release,
// click, double click, long press and auto-repeat.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   ev (slave)       : key_i in; held_o and event pulses out
//   state_o          : current FSM state, for observation
// All outputs are registered; each pulse appears the cycle after the edge
// or terminal count that caused it.
module key_event
   import key_event_pkg::*;
#(
   parameter logic ACTIVE_LEVEL = 1'b1,
   parameter int   LONG_TIME    = LONG_TIME_12M,
   parameter int   DCLICK_TIME  = DCLICK_TIME_12M,
   parameter int   REPEAT_TIME  = REPEAT_TIME_12M,
   parameter int   CNT_BITS     = CNT_BITS_12M
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   key_event_if.slave  ev,
   output state_t      state_o
);

   // Terminal counts: cnt == X-1 gives exactly X cycles in the state.
   localparam logic [CNT_BITS-1:0] LONG_TC   = CNT_BITS'(LONG_TIME - 1);
   localparam logic [CNT_BITS-1:0] DCLICK_TC = CNT_BITS'(DCLICK_TIME - 1);
   localparam logic [CNT_BITS-1:0] REPEAT_TC = CNT_BITS'(REPEAT_TIME - 1);

   logic key_d;
   logic rise;
   logic fall;

   state_t              state, state_n;
   logic [CNT_BITS-1:0] cnt;
   logic                cnt_clr;

   logic press_n, release_n, click_n, dclick_n, long_n, repeat_n;
   logic press_q, release_q, click_q, dclick_q, long_q, repeat_q;

   key_edge #(.ACTIVE_LEVEL(ACTIVE_LEVEL)) u_edge (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key_i   (ev.key_i),
      .key_d   (key_d),
      .rise    (rise),
      .fall    (fall)
   );

   // Next state and next pulse values. Where two causes meet in one
   // cycle the key edge is checked first so it takes priority.
   always_comb begin
      state_n   = state;
      cnt_clr   = 1'b0;
      press_n   = 1'b0;
      release_n = 1'b0;
      click_n   = 1'b0;
      dclick_n  = 1'b0;
      long_n    = 1'b0;
      repeat_n  = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_n = PRESS1;
               press_n = 1'b1;
            end
         end
         PRESS1: begin
            if (fall) begin
               state_n   = WAIT2;
               release_n = 1'b1;
            end else if (cnt == LONG_TC) begin
               state_n = LONG;
               long_n  = 1'b1;
            end
         end
         WAIT2: begin
            if (rise) begin
               state_n  = PRESS2;
               press_n  = 1'b1;
               dclick_n = 1'b1;
            end else if (cnt == DCLICK_TC) begin
               state_n = IDLE;
               click_n = 1'b1;
            end
         end
         PRESS2: begin
            if (fall) begin
               state_n   = IDLE;
               release_n = 1'b1;
            end
         end
         LONG: begin
            if (fall) begin
               state_n   = IDLE;
               release_n = 1'b1;
            end else if (cnt == REPEAT_TC) begin
               repeat_n = 1'b1;
               cnt_clr  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (state_n != state) cnt_clr = 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         click_q   <= 1'b0;
         dclick_q  <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_clr ? '0 : cnt + CNT_BITS'(1);
         press_q   <= press_n;
         release_q <= release_n;
         click_q   <= click_n;
         dclick_q  <= dclick_n;
         long_q    <= long_n;
         repeat_q  <= repeat_n;
      end
   end

   // key_d is already the registered pressed level.
   assign ev.held_o    = key_d;
   assign ev.press_o   = press_q;
   assign ev.release_o = release_q;
   assign ev.click_o   = click_q;
   assign ev.dclick_o  = dclick_q;
   assign ev.long_o    = long_q;
   assign ev.repeat_o  = repeat_q;
   assign state_o      = state;

endmodule
